operand_fetch_ctrl: RTL and testbench

Sequencer for the single shared register-file read port. It takes one operand-fetch request from decode. It then time-multiplexes the read address to load the left input register (strobe c11) and the right input register (strobe c12). It pulses done when the operands are ready for the ALU. Instances sit between decode and the register file / input-register pair, and are gated by the global run enable.

---
 rtl/operand_fetch_ctrl.sv | 108 ++++++++++
 tb/tb_operand_fetch_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/operand_fetch_ctrl.sv
// Operand fetch sequencer: steps the single shared register-file read port
// through the left and right operand reads, then pulses done.
// Ports:
//   clock, reset (async, active-high), run (global enable; low freezes all state)
//   req_valid/req_ready/req_lsel/req_rsel/req_lneed/req_rneed : fetch request from decode
//   rd_addr : register-file read address; c11/c12 : left/right input-register load strobes
//   busy (state != IDLE), done (one-cycle pulse), fetch_count (completed fetches, wraps)
module operand_fetch_ctrl #(
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              run,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_lsel,
    input  logic [ADDR_W-1:0] req_rsel,
    input  logic              req_lneed,
    input  logic              req_rneed,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              c11,
    output logic              c12,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  fetch_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        READ_L = 2'd1,
        READ_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] lsel_q;
    logic [ADDR_W-1:0] rsel_q;
    logic              lneed_q;
    logic              rneed_q;
    logic              accept;

    assign accept = req_valid && req_ready;
    assign busy   = (state != IDLE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            lsel_q      <= '0;
            rsel_q      <= '0;
            lneed_q     <= 1'b0;
            rneed_q     <= 1'b0;
            fetch_count <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                lsel_q  <= req_lsel;
                rsel_q  <= req_rsel;
                lneed_q <= req_lneed;
                rneed_q <= req_rneed;
            end
            // A fetch completes on the edge that leaves DONE.
            if (state == DONE && run) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end
    end

    // Outputs decode the state register and are gated by run, so a paused
    // step re-presents its strobe exactly once when run returns. rd_addr is
    // not gated by run so the address stays stable through a pause.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rd_addr   = '0;
        c11       = 1'b0;
        c12       = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                req_ready = run;
                if (req_valid && run) begin
                    if (req_lneed)      state_nxt = READ_L;
                    else if (req_rneed) state_nxt = READ_R;
                    else                state_nxt = DONE;
                end
            end
            READ_L: begin
                rd_addr = lsel_q;
                // lneed_q is always set in this state; keeps the strobe tied to the request.
                c11     = run && lneed_q;
                if (run) state_nxt = rneed_q ? READ_R : DONE;
            end
            READ_R: begin
                rd_addr = rsel_q;
                c12     = run;
                if (run) state_nxt = DONE;
            end
            DONE: begin
                done = run;
                if (run) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
module tb_operand_fetch_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       run;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_lsel;
    logic [1:0] req_rsel;
    logic       req_lneed;
    logic       req_rneed;
    logic [1:0] rd_addr;
    logic       c11;
    logic       c12;
    logic       busy;
    logic       done;
    logic [7:0] fetch_count;

    int n_checks = 0;
    int n_err    = 0;

    // Register file contents and the left/right input registers it feeds.
    logic [7:0] regs [4];
    logic [7:0] left_reg;
    logic [7:0] right_reg;
    int n_c11 = 0;
    int n_c12 = 0;
    int n_done = 0;
    int b_c11, b_c12, b_done;

    operand_fetch_ctrl #(.ADDR_W(2), .CNT_W(8)) dut (
        .clock       (clock),
        .reset       (reset),
        .run         (run),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_lsel    (req_lsel),
        .req_rsel    (req_rsel),
        .req_lneed   (req_lneed),
        .req_rneed   (req_rneed),
        .rd_addr     (rd_addr),
        .c11         (c11),
        .c12         (c12),
        .busy        (busy),
        .done        (done),
        .fetch_count (fetch_count)
    );

    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            left_reg  <= 8'h00;
            right_reg <= 8'h00;
        end else begin
            if (c11) begin
                left_reg <= regs[rd_addr];
                n_c11    <= n_c11 + 1;
            end
            if (c12) begin
                right_reg <= regs[rd_addr];
                n_c12     <= n_c12 + 1;
            end
            if (done) n_done <= n_done + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_c11  = n_c11;
        b_c12  = n_c12;
        b_done = n_done;
    endtask

    initial begin
        regs[0] = 8'h11; regs[1] = 8'h22; regs[2] = 8'h33; regs[3] = 8'h44;
        reset = 1'b1; run = 1'b0; req_valid = 1'b0;
        req_lsel = 2'd0; req_rsel = 2'd0; req_lneed = 1'b0; req_rneed = 1'b0;
        repeat (2) @(negedge clock);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cnt", fetch_count, 0);

        // Idle after reset with run high
        reset = 1'b0; run = 1'b1;
        @(negedge clock);
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_c11", c11, 0);
        chk("idle_c12", c12, 0);
        chk("idle_done", done, 0);
        chk("idle_addr", rd_addr, 0);

        // Both operands: lsel=2, rsel=3
        snap();
        req_valid = 1'b1; req_lsel = 2'd2; req_rsel = 2'd3; req_lneed = 1'b1; req_rneed = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("b_c11", c11, 1);
        chk("b_addr_l", rd_addr, 2);
        chk("b_c12_0", c12, 0);
        chk("b_ready_0", req_ready, 0);
        chk("b_busy", busy, 1);
        @(negedge clock);
        chk("b_c12", c12, 1);
        chk("b_c11_0", c11, 0);
        chk("b_addr_r", rd_addr, 3);
        chk("b_left", left_reg, 8'h33);
        @(negedge clock);
        chk("b_done", done, 1);
        chk("b_addr_0", rd_addr, 0);
        chk("b_right", right_reg, 8'h44);
        @(negedge clock);
        chk("b_done_0", done, 0);
        chk("b_ready", req_ready, 1);
        chk("b_cnt", fetch_count, 1);
        chk("b_n_c11", n_c11 - b_c11, 1);
        chk("b_n_c12", n_c12 - b_c12, 1);

        // Right operand only: rsel=1
        snap();
        req_valid = 1'b1; req_lsel = 2'd2; req_rsel = 2'd1; req_lneed = 1'b0; req_rneed = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("r_c11_0", c11, 0);
        chk("r_c12", c12, 1);
        chk("r_addr", rd_addr, 1);
        @(negedge clock);
        chk("r_done", done, 1);
        @(negedge clock);
        chk("r_cnt", fetch_count, 2);
        chk("r_right", right_reg, 8'h22);
        chk("r_n_c11", n_c11 - b_c11, 0);

        // No operands
        snap();
        req_valid = 1'b1; req_lsel = 2'd3; req_rsel = 2'd2; req_lneed = 1'b0; req_rneed = 1'b0;
        @(negedge clock);
        req_valid = 1'b0;
        chk("n_done", done, 1);
        chk("n_addr", rd_addr, 0);
        chk("n_c11", c11, 0);
        chk("n_c12", c12, 0);
        @(negedge clock);
        chk("n_done_0", done, 0);
        chk("n_cnt", fetch_count, 3);
        chk("n_strobes", (n_c11 - b_c11) + (n_c12 - b_c12), 0);

        // run paused for 3 cycles in READ_L: lsel=1, rsel=0
        snap();
        req_valid = 1'b1; req_lsel = 2'd1; req_rsel = 2'd0; req_lneed = 1'b1; req_rneed = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        chk("p_c11", c11, 1);
        run = 1'b0;
        #1;
        chk("p_c11_off", c11, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("p_hold_c11", c11, 0);
            chk("p_hold_addr", rd_addr, 1);
            chk("p_hold_ready", req_ready, 0);
            chk("p_hold_busy", busy, 1);
        end
        run = 1'b1;
        #1;
        chk("p_resume_c11", c11, 1);
        @(negedge clock);
        chk("p_c12", c12, 1);
        chk("p_addr_r", rd_addr, 0);
        @(negedge clock);
        chk("p_done", done, 1);
        @(negedge clock);
        chk("p_cnt", fetch_count, 4);
        chk("p_n_c11", n_c11 - b_c11, 1);
        chk("p_n_c12", n_c12 - b_c12, 1);
        chk("p_n_done", n_done - b_done, 1);
        chk("p_left", left_reg, 8'h22);
        chk("p_right", right_reg, 8'h11);

        // Reset during READ_R
        snap();
        req_valid = 1'b1; req_lsel = 2'd0; req_rsel = 2'd2; req_lneed = 1'b1; req_rneed = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        chk("x_c12", c12, 1);
        reset = 1'b1;
        #1;
        chk("x_busy", busy, 0);
        chk("x_c12_0", c12, 0);
        chk("x_cnt", fetch_count, 0);
        chk("x_left", left_reg, 0);
        repeat (2) @(negedge clock);
        chk("x_done_0", done, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        chk("x_n_done", n_done - b_done, 0);
        chk("x_ready", req_ready, 1);

        // 256 back-to-back no-operand fetches wrap the counter
        snap();
        req_valid = 1'b1; req_lneed = 1'b0; req_rneed = 1'b0;
        repeat (510) @(negedge clock);
        chk("w_cnt_ff", fetch_count, 8'hFF);
        repeat (2) @(negedge clock);
        req_valid = 1'b0;
        chk("w_cnt_wrap", fetch_count, 0);
        chk("w_n_done", n_done - b_done, 256);
        @(negedge clock);
        chk("w_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
